// File: rtl/data_mem_responder_pkg.sv
// Shared types for the memory-stage data path: address/data words, byte-lane
// write mask and the response FSM encoding of the data-memory responder.
package data_mem_responder_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  byte_en_t;

    // Longest supported request-to-response delay; sizes the latency counter.
    localparam int MEM_LATENCY_MAX = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_rsp_state_t;

endpackage

// File: rtl/data_mem_responder_ram.sv
// Single-port word array with per-byte-lane write enables. The index is
// applied combinationally; the read word is registered on every rising edge.
module byte_en_ram
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] idx,
    input  byte_en_t         wr_en,
    input  data_t            wdata,
    output data_t            rdata
);

    data_t mem [DEPTH_WORDS];

    // Byte-masked write and read-first word sample at the same index.
    // NOTE: the array and its read register carry no reset; memories are not
    // cleared, so a reset branch here would only break RAM inference.
    always_ff @(posedge clk) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (wr_en[lane]) begin
                mem[idx][8*lane +: 8] <= wdata[8*lane +: 8];
            end
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one word load/store per handshake, performs
// the byte-masked write at acceptance, samples the read word on the edge that
// enters RESP and returns a one-cycle response LATENCY cycles after acceptance.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     req_valid,
    output logic     req_ready,
    input  addr_t    req_addr,
    input  byte_en_t req_byte_en,
    input  data_t    req_wdata,
    output logic     rsp_valid,
    output data_t    rsp_rdata,
    output logic     rsp_error
);

    localparam int             IDX_W    = $clog2(DEPTH_WORDS);
    localparam int             CNT_W    = $clog2(MEM_LATENCY_MAX);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    mem_rsp_state_t   state;
    mem_rsp_state_t   state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             started;
    logic             accept;
    logic             req_oor;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] ram_idx;
    logic             write_q;
    logic             error_q;
    byte_en_t         ram_wr_en;
    data_t            ram_rdata;
    logic             unused_addr_lsbs;

    // Byte offset within the word is meaningless for whole-word access.
    assign unused_addr_lsbs = ^req_addr[1:0];

    assign req_idx   = req_addr[IDX_W+1:2];
    assign req_oor   = |req_addr[31:IDX_W+2];
    // Held low through reset and until the first edge after release.
    assign req_ready = started && (state != BUSY);
    assign accept    = req_valid && req_ready;
    // The accepting edge uses the live index; BUSY re-reads the captured one
    // so the word sampled on entry to RESP reflects the stored address.
    assign ram_idx   = accept ? req_idx : idx_q;
    assign ram_wr_en = (accept && !req_oor) ? req_byte_en : '0;

    byte_en_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk   (clk),
        .idx   (ram_idx),
        .wr_en (ram_wr_en),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    // FSM state register; reset drops any pending response immediately.
    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request capture, latency countdown and ready qualification.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started <= 1'b0;
            cnt     <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            started <= 1'b1;
            if (accept) begin
                cnt     <= CNT_LOAD;
                idx_q   <= req_idx;
                write_q <= |req_byte_en;
                error_q <= req_oor;
            end else if (state == BUSY) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Next-state selection and response outputs, zero outside RESP.
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        rsp_valid = 1'b0;
        rsp_error = 1'b0;
        rsp_rdata = '0;
        unique case (state)
            IDLE, RESP: begin
                if (accept) begin
                    state_nxt = (LATENCY > 1) ? BUSY : RESP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state == RESP) begin
            rsp_valid = 1'b1;
            rsp_error = error_q;
            if (!write_q && !error_q) begin
                rsp_rdata = ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (LATENCY 1, 3, 4) with directed
// scenarios plus randomized traffic checked against a word-array model.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int LAT [3] = '{1, 3, 4};

    logic     clk = 1'b0;
    logic     rst       [3];
    logic     req_valid [3];
    logic     req_ready [3];
    addr_t    req_addr  [3];
    byte_en_t req_be    [3];
    data_t    req_wdata [3];
    logic     rsp_valid [3];
    data_t    rsp_rdata [3];
    logic     rsp_error [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_byte_en(req_be[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0])
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_l3 (
        .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_byte_en(req_be[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1])
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
        .clk(clk), .reset(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_addr(req_addr[2]), .req_byte_en(req_be[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_error(rsp_error[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input int i, input string tag);
        check({tag, "_valid"}, 32'(rsp_valid[i]), 32'd0);
        check({tag, "_rdata"}, rsp_rdata[i], 32'd0);
        check({tag, "_error"}, 32'(rsp_error[i]), 32'd0);
    endtask

    // One request from a negedge; returns at the negedge of its response cycle.
    task automatic do_req(input int i, input addr_t a, input byte_en_t be, input data_t wd,
                          input data_t exp_rd, input logic exp_err, input string tag);
        check({tag, "_ready"}, 32'(req_ready[i]), 32'd1);
        req_valid[i] = 1'b1;
        req_addr[i]  = a;
        req_be[i]    = be;
        req_wdata[i] = wd;
        @(posedge clk);
        for (int k = 1; k <= LAT[i]; k++) begin
            @(negedge clk);
            if (k == 1) req_valid[i] = 1'b0;
            if (k < LAT[i]) begin
                check({tag, "_busy_valid"}, 32'(rsp_valid[i]), 32'd0);
                check({tag, "_busy_ready"}, 32'(req_ready[i]), 32'd0);
            end else begin
                check({tag, "_rsp_valid"}, 32'(rsp_valid[i]), 32'd1);
                check({tag, "_rsp_rdata"}, rsp_rdata[i], exp_rd);
                check({tag, "_rsp_error"}, 32'(rsp_error[i]), 32'(exp_err));
            end
        end
    endtask

    initial begin
        data_t    ref_mem [16];
        addr_t    a;
        byte_en_t be;
        data_t    wd;
        data_t    exp_rd;
        logic     oor;
        int       w;

        for (int i = 0; i < 3; i++) begin
            rst[i]       = 1'b0;
            req_valid[i] = 1'b0;
            req_addr[i]  = '0;
            req_be[i]    = '0;
            req_wdata[i] = '0;
        end

        // Reset state: ready low, outputs zero while reset is held.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_ready", 32'(req_ready[i]), 32'd0);
            check_idle_outputs(i, "reset");
            rst[i] = 1'b1;
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("post_reset_ready", 32'(req_ready[i]), 32'd1);
        end

        // LATENCY=1: full write then immediate read-after-write.
        do_req(0, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, "l1_wr10");
        do_req(0, 32'h10, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0, "l1_rd10");
        // Partial write of lane 2, read back through an unaligned address.
        do_req(0, 32'h10, 4'b0100, 32'h00AA0000, 32'h0, 1'b0, "l1_pwr10");
        do_req(0, 32'h13, 4'b0000, 32'h0, 32'hDEAABEEF, 1'b0, "l1_rd13");

        // Back-to-back reads, one per cycle.
        do_req(0, 32'h0, 4'b1111, 32'd1, 32'h0, 1'b0, "l1_wr0");
        do_req(0, 32'h4, 4'b1111, 32'd2, 32'h0, 1'b0, "l1_wr4");
        do_req(0, 32'h8, 4'b1111, 32'd3, 32'h0, 1'b0, "l1_wr8");
        req_valid[0] = 1'b1;
        req_be[0]    = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            req_addr[0] = 32'(k * 4);
            @(posedge clk);
            @(negedge clk);
            check("b2b_valid", 32'(rsp_valid[0]), 32'd1);
            check("b2b_rdata", rsp_rdata[0], 32'(k + 1));
        end
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs(0, "b2b_after");

        // Out-of-range write is dropped even though its index aliases word 0.
        do_req(0, 32'h1000, 4'b1111, 32'hFFFFFFFF, 32'h0, 1'b1, "l1_oor_wr");
        do_req(0, 32'h0, 4'b0000, 32'h0, 32'd1, 1'b0, "l1_rd0_kept");
        do_req(0, 32'h1000, 4'b0000, 32'h0, 32'h0, 1'b1, "l1_oor_rd");

        // LATENCY=3: valid held through BUSY is only taken in RESP.
        do_req(1, 32'h10, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, "l3_wr10");
        do_req(1, 32'h14, 4'b1111, 32'h5A5A1234, 32'h0, 1'b0, "l3_wr14");
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h10;
        req_be[1]    = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        req_addr[1] = 32'h14;
        check("l3_hold_b1_ready", 32'(req_ready[1]), 32'd0);
        check("l3_hold_b1_valid", 32'(rsp_valid[1]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("l3_hold_b2_ready", 32'(req_ready[1]), 32'd0);
        check("l3_hold_b2_valid", 32'(rsp_valid[1]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("l3_hold_rsp_valid", 32'(rsp_valid[1]), 32'd1);
        check("l3_hold_rsp_rdata", rsp_rdata[1], 32'hCAFEF00D);
        check("l3_hold_rsp_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("l3_second_b1_ready", 32'(req_ready[1]), 32'd0);
        check("l3_second_b1_valid", 32'(rsp_valid[1]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("l3_second_b2_valid", 32'(rsp_valid[1]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("l3_second_rsp_valid", 32'(rsp_valid[1]), 32'd1);
        check("l3_second_rsp_rdata", rsp_rdata[1], 32'h5A5A1234);

        // LATENCY=4: reset two cycles into a read discards the response.
        do_req(2, 32'h20, 4'b1111, 32'h12345678, 32'h0, 1'b0, "l4_wr20");
        req_valid[2] = 1'b1;
        req_addr[2]  = 32'h20;
        req_be[2]    = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst[2] = 1'b0;
        #1;
        check("l4_rst_ready", 32'(req_ready[2]), 32'd0);
        check_idle_outputs(2, "l4_rst");
        repeat (3) begin
            @(negedge clk);
            check("l4_rst_hold_valid", 32'(rsp_valid[2]), 32'd0);
        end
        rst[2] = 1'b1;
        @(negedge clk);
        check("l4_release_ready", 32'(req_ready[2]), 32'd1);
        check_idle_outputs(2, "l4_release");
        repeat (4) begin
            @(negedge clk);
            check("l4_no_stale_rsp", 32'(rsp_valid[2]), 32'd0);
        end
        do_req(2, 32'h20, 4'b0000, 32'h0, 32'h12345678, 1'b0, "l4_rd20_kept");

        // Randomized traffic on a 16-word window, including out-of-range hits.
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 16; k++) begin
                ref_mem[k] = $urandom;
                do_req(i, 32'h100 + 32'(k * 4), 4'b1111, ref_mem[k], 32'h0, 1'b0, "rnd_init");
            end
            repeat (40) begin
                w   = int'($urandom_range(15));
                a   = 32'h100 + 32'(w * 4) + 32'($urandom_range(3));
                oor = ($urandom_range(3) == 0);
                if (oor) a = a | (32'h1 << $urandom_range(31, 12));
                be  = 4'($urandom_range(15));
                wd  = $urandom;
                exp_rd = 32'h0;
                if (!oor) begin
                    if (be == 4'b0000) begin
                        exp_rd = ref_mem[w];
                    end else begin
                        for (int lane = 0; lane < 4; lane++) begin
                            if (be[lane]) ref_mem[w][8*lane +: 8] = wd[8*lane +: 8];
                        end
                    end
                end
                do_req(i, a, be, wd, exp_rd, oor, "rnd");
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
